// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bnn_pkg
// Brief   : Shared constants, FSM state type and width helper for the binary
//           fully-connected engine.
// Revision: 1.0 - initial release
// ============================================================================
package bnn_pkg;

  localparam int N_IN_DEF    = 576;
  localparam int N_CLASS_DEF = 10;
  localparam int ACC_W_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2
  } fc_state_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_fc_wram.sv
`default_nettype none
// ============================================================================
// Module  : bnn_fc_wram
// Brief   : N_IN x N_CLASS weight register array with bit-serial input-major
//           write counter, full flag and combinational row read.
// Revision: 1.0 - initial release
// ============================================================================
module bnn_fc_wram
  import bnn_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int ROW_W   = clog2(N_IN),
  parameter int COL_W   = clog2(N_CLASS)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_we,
  input  logic               i_wbit,
  input  logic [ROW_W-1:0]   i_rd_addr,
  output logic [N_CLASS-1:0] o_rd_data,
  output logic               o_full
);

  logic [N_CLASS-1:0] r_mem [N_IN];
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic               r_full;

  logic w_last_col;
  logic w_last_row;

  assign w_last_col = (r_col == COL_W'(N_CLASS - 1));
  assign w_last_row = (r_row == ROW_W'(N_IN - 1));

  // Contents survive reset so a reloaded engine can reuse them.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[r_row][r_col] <= i_wbit;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_row  <= '0;
      r_col  <= '0;
      r_full <= 1'b0;
    end else if (i_we) begin
      if (w_last_col) begin
        r_col <= '0;
        if (w_last_row) begin
          r_row  <= '0;
          r_full <= 1'b1;
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
  assign o_full    = r_full;

endmodule
`default_nettype wire

// File: rtl/bnn_fc_engine.sv
`default_nettype none
// ============================================================================
// Module  : bnn_fc_engine
// Brief   : Binary FC layer: accumulates per-class XNOR-popcounts over a
//           bit-serial activation frame, then streams class scores/signs.
// Revision: 1.0 - initial release
// ============================================================================
module bnn_fc_engine
  import bnn_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_CLASS = N_CLASS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fc_din,
  input  logic             fc_invalid,
  input  logic             fc_weight_en,
  input  logic             fc_weight,
  output logic             fc_result,
  output logic [ACC_W-1:0] fc_score,
  output logic [3:0]       fc_class,
  output logic             fc_result_valid,
  output logic             fc_done,
  output logic             wt_ready,
  output logic             fc_overrun
);

  localparam int IN_W  = clog2(N_IN);
  localparam int CLS_W = clog2(N_CLASS);

  generate
    if (ACC_W < clog2(N_IN + 1) || N_CLASS > 16) begin : g_bad_params
      $error("bnn_fc_engine: ACC_W too narrow or N_CLASS exceeds fc_class range");
    end
  endgenerate

  fc_state_t          r_state;
  logic [IN_W-1:0]    r_in_cnt;
  logic [CLS_W-1:0]   r_emit_cnt;
  logic [ACC_W-1:0]   r_acc [N_CLASS];
  logic               r_result;
  logic [ACC_W-1:0]   r_score;
  logic [3:0]         r_class;
  logic               r_valid;
  logic               r_done;
  logic               r_overrun;

  logic [N_CLASS-1:0] w_wrow;
  logic [N_CLASS-1:0] w_xnor;
  logic               w_capture;
  logic               w_wt_accept;
  logic               w_drop;
  logic               w_last_in;
  logic               w_last_cls;
  logic [ACC_W-1:0]   w_sel_acc;
  logic               w_sign;

  assign w_capture   = fc_invalid && (r_state != EMIT);
  assign w_wt_accept = rstn && fc_weight_en && (r_state == IDLE) && !fc_invalid;
  assign w_drop      = (fc_weight_en && !((r_state == IDLE) && !fc_invalid))
                    || (fc_invalid && (r_state == EMIT));
  assign w_last_in   = (r_in_cnt == IN_W'(N_IN - 1));
  assign w_last_cls  = (r_emit_cnt == CLS_W'(N_CLASS - 1));
  assign w_xnor      = ~(w_wrow ^ {N_CLASS{fc_din}});
  assign w_sel_acc   = r_acc[r_emit_cnt];
  // Sign rule 2*score >= N_IN, evaluated one bit wider to avoid a halving.
  assign w_sign      = ({w_sel_acc, 1'b0} >= (ACC_W + 1)'(N_IN));

  bnn_fc_wram #(
    .N_IN    (N_IN),
    .N_CLASS (N_CLASS),
    .ROW_W   (IN_W),
    .COL_W   (CLS_W)
  ) u_wram (
    .clk       (clk),
    .rstn      (rstn),
    .i_we      (w_wt_accept),
    .i_wbit    (fc_weight),
    .i_rd_addr (r_in_cnt),
    .o_rd_data (w_wrow),
    .o_full    (wt_ready)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_in_cnt   <= '0;
      r_emit_cnt <= '0;
      r_result   <= 1'b0;
      r_score    <= '0;
      r_class    <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      for (int c = 0; c < N_CLASS; c++) r_acc[c] <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (w_drop) r_overrun <= 1'b1;
      case (r_state)
        IDLE, ACC: begin
          if (w_capture) begin
            for (int c = 0; c < N_CLASS; c++) r_acc[c] <= r_acc[c] + ACC_W'(w_xnor[c]);
            if (w_last_in) begin
              r_in_cnt <= '0;
              r_state  <= EMIT;
            end else begin
              r_in_cnt <= r_in_cnt + IN_W'(1);
              r_state  <= ACC;
            end
          end
        end
        EMIT: begin
          r_valid  <= 1'b1;
          r_score  <= w_sel_acc;
          r_result <= w_sign;
          r_class  <= 4'(r_emit_cnt);
          r_done   <= w_last_cls;
          if (w_last_cls) begin
            r_emit_cnt <= '0;
            r_state    <= IDLE;
            for (int c = 0; c < N_CLASS; c++) r_acc[c] <= '0;
          end else begin
            r_emit_cnt <= r_emit_cnt + CLS_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fc_result       = r_result;
  assign fc_score        = r_score;
  assign fc_class        = r_class;
  assign fc_result_valid = r_valid;
  assign fc_done         = r_done;
  assign fc_overrun      = r_overrun;

endmodule
`default_nettype wire
